// File: rtl/bist_pkg.sv
// Shared BIST definitions: FSM encoding and default LFSR configuration, common
// to the pattern generator and the signature analyser.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } bist_state_e;

  localparam int unsigned BIST_WIDTH4 = 4;

  // x^4 + x^3 + 1: state[3] and state[2] feed the XOR
  localparam logic [BIST_WIDTH4-1:0] BIST_TAPS4 = 4'b1100;

  // Reset value shared by generator LFSR and analyser signature register
  localparam logic [BIST_WIDTH4-1:0] BIST_SEED_DEFAULT4 = 4'b0001;

endpackage : bist_pkg

// File: rtl/bist_pattern_generator_lfsr_core.sv
// Fibonacci-style shift-left LFSR with parallel load and step enable.
module lfsr_core #(
  parameter int unsigned          WIDTH = 4,
  parameter logic [WIDTH-1:0]     TAPS  = 4'b1100,
  parameter logic [WIDTH-1:0]     SEED  = 4'b0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic             fb_c;

  // Load has priority over stepping
  always_comb begin
    fb_c    = ^(state_q & TAPS);
    state_d = state_q;
    if (load) begin
      state_d = load_value;
    end else if (enable) begin
      state_d = {state_q[WIDTH-2:0], fb_c};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule : lfsr_core

// File: rtl/bist_pattern_generator.sv
// BIST stimulus source: session FSM, pattern counter and registered outputs
// around an LFSR core. Output registers are loaded from the next-state view.
module bist_pattern_generator
  import bist_pkg::*;
#(
  parameter int unsigned      WIDTH        = 4,
  parameter logic [WIDTH-1:0] TAPS         = BIST_TAPS4,
  parameter int unsigned      NUM_PATTERNS = 15,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = BIST_SEED_DEFAULT4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             hold,
  output logic [WIDTH-1:0] pattern,
  output logic             pattern_valid,
  output logic             sa_rst,
  output logic             busy,
  output logic             done,
  output logic             lockup_err
);

  localparam int unsigned      CNT_W    = $clog2(NUM_PATTERNS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PATTERNS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  bist_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic             pattern_valid_q, pattern_valid_d;
  logic             sa_rst_q, sa_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lockup_err_q, lockup_err_d;

  logic             lfsr_load_c;
  logic             lfsr_en_c;
  logic             emit_c;
  logic [WIDTH-1:0] lfsr_state;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED_DEFAULT)
  ) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .load       (lfsr_load_c),
    .load_value (seed_in),
    .enable     (lfsr_en_c),
    .state      (lfsr_state)
  );

  // cnt_q counts patterns already latched into the output register; a pattern
  // is latched at the edge that precedes the cycle in which it is applied.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lockup_err_d = lockup_err_q;
    lfsr_load_c  = 1'b0;
    lfsr_en_c    = 1'b0;
    emit_c       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (seed_load) begin
          if (seed_in != '0) begin
            lfsr_load_c  = 1'b1;
            lockup_err_d = 1'b0;
          end else begin
            lockup_err_d = 1'b1;
          end
        end
        if (start) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      ST_INIT: begin
        state_d = ST_RUN;
        emit_c  = ~hold;
      end
      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          emit_c = ~hold;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (emit_c) begin
      lfsr_en_c = 1'b1;
      cnt_d     = cnt_q + CNT_ONE;
    end

    pattern_d       = emit_c ? lfsr_state : '0;
    pattern_valid_d = emit_c;
    sa_rst_d        = (state_d == ST_INIT);
    busy_d          = (state_d == ST_INIT) || (state_d == ST_RUN);
    done_d          = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      pattern_q       <= '0;
      pattern_valid_q <= 1'b0;
      sa_rst_q        <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      lockup_err_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pattern_q       <= pattern_d;
      pattern_valid_q <= pattern_valid_d;
      sa_rst_q        <= sa_rst_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      lockup_err_q    <= lockup_err_d;
    end
  end

  assign pattern       = pattern_q;
  assign pattern_valid = pattern_valid_q;
  assign sa_rst        = sa_rst_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign lockup_err    = lockup_err_q;

endmodule : bist_pattern_generator
